// File: rtl/coherence_arbiter_n.sv
// N-cache MSI snoopy coherence controller and round-robin RAM arbiter for the L1 dcaches.
// Optional statistics counters are enabled by defining COHERENCE_ARB_STATS_EN.
module coherence_arbiter_n #(
    parameter int unsigned CPUS     = 2,
    parameter int unsigned BLKWORDS = 2,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [CPUS-1:0]    dREN,
    input  logic [CPUS-1:0]    dWEN,
    input  logic [CPUS-1:0]    cctrans,
    input  logic [CPUS-1:0]    ccwrite,
    input  logic [CPUS*AW-1:0] daddr,
    input  logic [CPUS*DW-1:0] dstore,
    output logic [CPUS-1:0]    dwait,
    output logic [CPUS*DW-1:0] dload,
    output logic [CPUS-1:0]    ccwait,
    output logic [CPUS-1:0]    ccinv,
    output logic [CPUS*AW-1:0] ccsnoopaddr,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    input  logic [DW-1:0]      ramload,
    input  logic               ram_wait
`ifdef COHERENCE_ARB_STATS_EN
    ,
    output logic [31:0]        stat_hits,
    output logic [31:0]        stat_invs,
    output logic [31:0]        stat_xacts
`endif
);
    localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int unsigned WW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
    localparam logic [WW-1:0] WLAST = WW'(BLKWORDS - 1);

    typedef enum logic [2:0] {IDLE, SNOOP, XFER, WB, ISNOOP, INV} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  req_q, req_d, ptr_q, ptr_d;
    logic [WW-1:0]  w_q, w_d;
    logic           wm_q, wm_d;
    logic           found, hit, done;
    logic [IW-1:0]  sel, resp;
    int unsigned    idx;
    logic [CPUS-1:0] others;
    logic [AW-1:0]  req_addr;

    assign others      = ~(CPUS'(1) << req_q);
    assign req_addr    = daddr[req_q*AW +: AW];
    assign ccsnoopaddr = {CPUS{req_addr}};

    // Round-robin scan starting at ptr; first requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            idx = (32'(ptr_q) + k) % CPUS;
            if (!found && (dREN[idx] | dWEN[idx] | cctrans[idx])) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    always_comb begin
        hit  = 1'b0;
        resp = '0;
        for (int unsigned i = 0; i < CPUS; i++) begin
            if (!hit && ccwrite[i] && (IW'(i) != req_q)) begin
                hit  = 1'b1;
                resp = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        wm_d    = wm_q;
        done    = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                req_d = sel;
                wm_d  = cctrans[sel] & dREN[sel];
                w_d   = '0;
                if (dREN[sel])      state_d = SNOOP;
                else if (dWEN[sel]) state_d = WB;
                else                state_d = ISNOOP;
            end
            SNOOP: begin
                state_d = XFER;
                w_d     = '0;
            end
            XFER, WB: if (!ram_wait) begin
                w_d = w_q + 1'b1;
                if (w_q == WLAST) done = 1'b1;
            end
            ISNOOP:  state_d = INV;
            INV:     done = 1'b1;
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d = IDLE;
            w_d     = '0;
            ptr_d   = (req_q == IW'(CPUS - 1)) ? '0 : req_q + 1'b1;
        end
    end

    always_comb begin
        dwait    = '1;
        dload    = '0;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            SNOOP, ISNOOP: ccwait = others;
            XFER: begin
                ccwait         = others;
                ramaddr        = req_addr;
                dwait[req_q]   = ram_wait;
                // Modified data goes cache-to-cache and to RAM in the same cycle.
                if (hit) begin
                    ramWEN                  = 1'b1;
                    ramstore                = dstore[resp*DW +: DW];
                    dload[req_q*DW +: DW]   = dstore[resp*DW +: DW];
                    dwait[resp]             = ram_wait;
                end else begin
                    ramREN                  = 1'b1;
                    dload[req_q*DW +: DW]   = ramload;
                end
                if (wm_q && (w_q == WLAST)) ccinv = others;
            end
            WB: begin
                ramWEN       = 1'b1;
                ramaddr      = req_addr;
                ramstore     = dstore[req_q*DW +: DW];
                dwait[req_q] = ram_wait;
            end
            INV: begin
                ccinv        = others;
                dwait[req_q] = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            req_q   <= '0;
            ptr_q   <= '0;
            w_q     <= '0;
            wm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            wm_q    <= wm_d;
        end
    end

`ifdef COHERENCE_ARB_STATS_EN
    logic [31:0] hits_q, invs_q, xacts_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hits_q  <= '0;
            invs_q  <= '0;
            xacts_q <= '0;
        end else if (done) begin
            if (xacts_q != '1) xacts_q <= xacts_q + 32'd1;
            if ((state_q == XFER) && hit && (hits_q != '1)) hits_q <= hits_q + 32'd1;
            if (((state_q == INV) || ((state_q == XFER) && wm_q)) && (invs_q != '1))
                invs_q <= invs_q + 32'd1;
        end
    end

    assign stat_hits  = hits_q;
    assign stat_invs  = invs_q;
    assign stat_xacts = xacts_q;
`endif
endmodule

// File: tb/tb_coherence_arbiter_n.sv
// Directed bench for coherence_arbiter_n: a 2-cache/2-word instance driven from a vector table
// and a 4-cache/4-word instance exercised with hand-written multi-cycle sequences.
module tb_coherence_arbiter_n;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    // 2-cache instance
    logic [1:0]  rd2, wr2, ct2, cw2, dwait2, ccwait2, ccinv2;
    logic [63:0] daddr2, dstore2, dload2, snoop2;
    logic        ren2, wen2, rw2;
    logic [31:0] raddr2, rstore2, rl2;

    // 4-cache instance
    logic [3:0]   rd4, wr4, ct4, cw4, dwait4, ccwait4, ccinv4;
    logic [127:0] daddr4, dstore4, dload4, snoop4;
    logic         ren4, wen4, rw4;
    logic [31:0]  raddr4, rstore4, rl4;

    coherence_arbiter_n #(.CPUS(2), .BLKWORDS(2), .AW(32), .DW(32)) u2 (
        .CLK(CLK), .nRST(nRST), .dREN(rd2), .dWEN(wr2), .cctrans(ct2), .ccwrite(cw2),
        .daddr(daddr2), .dstore(dstore2), .dwait(dwait2), .dload(dload2),
        .ccwait(ccwait2), .ccinv(ccinv2), .ccsnoopaddr(snoop2), .ramREN(ren2), .ramWEN(wen2),
        .ramaddr(raddr2), .ramstore(rstore2), .ramload(rl2), .ram_wait(rw2)
    );

    coherence_arbiter_n #(.CPUS(4), .BLKWORDS(4), .AW(32), .DW(32)) u4 (
        .CLK(CLK), .nRST(nRST), .dREN(rd4), .dWEN(wr4), .cctrans(ct4), .ccwrite(cw4),
        .daddr(daddr4), .dstore(dstore4), .dwait(dwait4), .dload(dload4),
        .ccwait(ccwait4), .ccinv(ccinv4), .ccsnoopaddr(snoop4), .ramREN(ren4), .ramWEN(wen4),
        .ramaddr(raddr4), .ramstore(rstore4), .ramload(rl4), .ram_wait(rw4)
    );

    typedef struct packed {
        logic [1:0]  rd, wr, ct, cw;
        logic        rw;
        logic [31:0] rl;
        logic [1:0]  dw, ccw, cci;
        logic        ren, wen;
        logic [31:0] addr, st, d0, d1;
    } vec_t;

    vec_t        tv[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned r;
    int unsigned order[3];
    int          wbdone;
    logic [3:0]  m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] a4(input int unsigned i);
        return 32'h1000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [31:0] s4(input int unsigned i);
        return 32'hC000_0000 + 32'(i);
    endfunction

    initial begin
        // rd wr ct cw rw rl | dwait ccwait ccinv ren wen addr store dload0 dload1
        tv.push_back('{2'b01,2'b00,2'b00,2'b00,1'b0,32'h11, 2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b01,2'b00,2'b00,2'b00,1'b0,32'h11, 2'b11,2'b10,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b01,2'b00,2'b00,2'b00,1'b0,32'h11, 2'b10,2'b10,2'b00,1'b1,1'b0,32'h100,32'h0, 32'h11,32'h0});
        tv.push_back('{2'b01,2'b00,2'b00,2'b00,1'b0,32'h22, 2'b10,2'b10,2'b00,1'b1,1'b0,32'h100,32'h0, 32'h22,32'h0});
        tv.push_back('{2'b11,2'b00,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b11,2'b00,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b01,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b11,2'b00,2'b00,2'b01,1'b1,32'h0,  2'b11,2'b01,2'b00,1'b0,1'b1,32'h200,32'hA0,32'h0, 32'hA0});
        tv.push_back('{2'b11,2'b00,2'b00,2'b01,1'b0,32'h0,  2'b00,2'b01,2'b00,1'b0,1'b1,32'h200,32'hA0,32'h0, 32'hA0});
        tv.push_back('{2'b11,2'b00,2'b00,2'b01,1'b0,32'h0,  2'b00,2'b01,2'b00,1'b0,1'b1,32'h200,32'hA0,32'h0, 32'hA0});
        tv.push_back('{2'b00,2'b00,2'b10,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b00,2'b00,2'b10,2'b00,1'b0,32'h0,  2'b11,2'b01,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b00,2'b00,2'b10,2'b00,1'b0,32'h0,  2'b01,2'b00,2'b01,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b00,2'b00,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b01,2'b00,2'b01,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b01,2'b00,2'b01,2'b00,1'b0,32'h0,  2'b11,2'b10,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b01,2'b00,2'b01,2'b00,1'b0,32'h33, 2'b10,2'b10,2'b00,1'b1,1'b0,32'h100,32'h0, 32'h33,32'h0});
        tv.push_back('{2'b01,2'b00,2'b01,2'b00,1'b1,32'h44, 2'b11,2'b10,2'b10,1'b1,1'b0,32'h100,32'h0, 32'h44,32'h0});
        tv.push_back('{2'b01,2'b00,2'b01,2'b00,1'b0,32'h44, 2'b10,2'b10,2'b10,1'b1,1'b0,32'h100,32'h0, 32'h44,32'h0});
        tv.push_back('{2'b00,2'b01,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b00,2'b01,2'b00,2'b00,1'b0,32'h0,  2'b10,2'b00,2'b00,1'b0,1'b1,32'h100,32'hA0,32'h0, 32'h0});
        tv.push_back('{2'b00,2'b01,2'b00,2'b00,1'b0,32'h0,  2'b10,2'b00,2'b00,1'b0,1'b1,32'h100,32'hA0,32'h0, 32'h0});
        tv.push_back('{2'b00,2'b00,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b10,2'b10,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b10,2'b10,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b01,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});
        tv.push_back('{2'b10,2'b10,2'b00,2'b00,1'b0,32'h55, 2'b01,2'b01,2'b00,1'b1,1'b0,32'h200,32'h0, 32'h0, 32'h55});
        tv.push_back('{2'b10,2'b10,2'b00,2'b00,1'b0,32'h66, 2'b01,2'b01,2'b00,1'b1,1'b0,32'h200,32'h0, 32'h0, 32'h66});
        tv.push_back('{2'b00,2'b00,2'b00,2'b00,1'b0,32'h0,  2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 32'h0, 32'h0});

        rd2 = '0; wr2 = '0; ct2 = '0; cw2 = '0; rw2 = 1'b0; rl2 = '0;
        daddr2  = {32'h200, 32'h100};
        dstore2 = {32'hB1, 32'hA0};
        rd4 = '0; wr4 = '0; ct4 = '0; cw4 = '0; rw4 = 1'b0; rl4 = '0;
        for (int i = 0; i < 4; i++) begin
            daddr4[i*32 +: 32]  = a4(i);
            dstore4[i*32 +: 32] = s4(i);
        end
        order[0] = 0; order[1] = 1; order[2] = 3;

        // Reset state
        repeat (2) @(negedge CLK);
        rd2 = 2'b11; rd4 = 4'hF;
        #1;
        chk("rst.dwait2", dwait2, 2'b11);
        chk("rst.cc2", {ccwait2, ccinv2}, 4'b0);
        chk("rst.ram2", {ren2, wen2, raddr2, rstore2}, 66'b0);
        chk("rst.dload2", dload2, 64'h0);
        chk("rst.dwait4", dwait4, 4'hF);
        chk("rst.cc4", {ccwait4, ccinv4}, 8'h0);
        chk("rst.ram4", {ren4, wen4, raddr4}, 34'h0);
        @(negedge CLK);
        rd2 = '0; rd4 = '0;
        nRST = 1'b1;

        // Table-driven 2-cache sequences
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge CLK);
            rd2 = tv[i].rd; wr2 = tv[i].wr; ct2 = tv[i].ct; cw2 = tv[i].cw;
            rw2 = tv[i].rw; rl2 = tv[i].rl;
            #1;
            chk($sformatf("v%0d.dwait", i), dwait2, tv[i].dw);
            chk($sformatf("v%0d.ccwait", i), ccwait2, tv[i].ccw);
            chk($sformatf("v%0d.ccinv", i), ccinv2, tv[i].cci);
            chk($sformatf("v%0d.ramREN", i), ren2, tv[i].ren);
            chk($sformatf("v%0d.ramWEN", i), wen2, tv[i].wen);
            chk($sformatf("v%0d.ramaddr", i), raddr2, tv[i].addr);
            chk($sformatf("v%0d.ramstore", i), rstore2, tv[i].st);
            chk($sformatf("v%0d.dload0", i), dload2[31:0], tv[i].d0);
            chk($sformatf("v%0d.dload1", i), dload2[63:32], tv[i].d1);
        end

        // A: simultaneous misses on 0,1,3 are granted in round-robin order
        for (int k = 0; k < 3; k++) begin
            r = order[k];
            m = ~(4'b1 << r);
            @(negedge CLK);
            if (k == 0) rd4 = 4'b1011;
            #1;
            chk($sformatf("A%0d.idle.dwait", k), dwait4, 4'hF);
            chk($sformatf("A%0d.idle.ren", k), ren4, 1'b0);
            @(negedge CLK); #1;
            chk($sformatf("A%0d.snoop.ccwait", k), ccwait4, m);
            for (int w = 0; w < 4; w++) begin
                @(negedge CLK);
                rl4 = 32'h4000 + 32'(r) * 32'h10 + 32'(w);
                #1;
                chk($sformatf("A%0d.w%0d.ren", k, w), ren4, 1'b1);
                chk($sformatf("A%0d.w%0d.addr", k, w), raddr4, a4(r));
                chk($sformatf("A%0d.w%0d.dwait", k, w), dwait4, m);
                chk($sformatf("A%0d.w%0d.dload", k, w), dload4[r*32 +: 32], rl4);
                if (w == 3) rd4[r] = 1'b0;
            end
        end

        // B: cache 2 misses, caches 1 and 3 both hold it Modified -> cache 1 supplies
        @(negedge CLK);
        rd4 = 4'b0100; cw4 = 4'b1010;
        #1;
        chk("B.idle.dwait", dwait4, 4'hF);
        @(negedge CLK); #1;
        chk("B.snoop.ccwait", ccwait4, 4'b1011);
        for (int i = 0; i < 4; i++)
            chk($sformatf("B.snoopaddr%0d", i), snoop4[i*32 +: 32], a4(2));
        for (int w = 0; w < 5; w++) begin
            @(negedge CLK);
            rw4 = (w == 0);
            #1;
            chk($sformatf("B.c%0d.dwait", w), dwait4, (w == 0) ? 4'hF : 4'b1001);
            chk($sformatf("B.c%0d.wen", w), {ren4, wen4}, 2'b01);
            chk($sformatf("B.c%0d.addr", w), raddr4, a4(2));
            chk($sformatf("B.c%0d.store", w), rstore4, s4(1));
            chk($sformatf("B.c%0d.dload", w), dload4[95:64], s4(1));
            if (w == 4) rd4 = '0;
        end
        @(negedge CLK);
        cw4 = '0;
        #1;
        chk("B.done.wen", wen4, 1'b0);

        // C: writeback from cache 0 with 3 wait cycles per word
        wbdone = 0;
        @(negedge CLK);
        wr4 = 4'b0001;
        #1;
        chk("C.idle.wen", wen4, 1'b0);
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge CLK);
                rw4 = (c != 3);
                #1;
                if (wen4 && !dwait4[0]) wbdone++;
                chk($sformatf("C.w%0d.c%0d.wen", w, c), wen4, 1'b1);
                chk($sformatf("C.w%0d.c%0d.dwait", w, c), dwait4, (c == 3) ? 4'b1110 : 4'hF);
                chk($sformatf("C.w%0d.c%0d.addr", w, c), raddr4, a4(0));
                chk($sformatf("C.w%0d.c%0d.store", w, c), rstore4, s4(0));
                if (w == 3 && c == 3) wr4 = '0;
            end
        end
        @(negedge CLK);
        rw4 = 1'b0;
        #1;
        if (wen4 && !dwait4[0]) wbdone++;
        chk("C.after.wen", wen4, 1'b0);
        chk("C.completions", 64'(wbdone), 64'd4);

        // D: reset during XFER at w=1, then restart of the same miss
        @(negedge CLK);
        rd4 = 4'b0010;
        #1;
        chk("D.idle.dwait", dwait4, 4'hF);
        @(negedge CLK); #1;
        chk("D.snoop.ccwait", ccwait4, 4'b1101);
        @(negedge CLK); #1;
        chk("D.w0.ren", ren4, 1'b1);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("D.rst.dwait", dwait4, 4'hF);
        chk("D.rst.ram", {ren4, wen4, raddr4}, 34'h0);
        chk("D.rst.cc", {ccwait4, ccinv4}, 8'h0);
        chk("D.rst.dload", dload4[63:0], 64'h0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("D.re.idle", {ren4, ccwait4}, 5'h0);
        @(negedge CLK); #1;
        chk("D.re.snoop", ccwait4, 4'b1101);
        for (int w = 0; w < 4; w++) begin
            @(negedge CLK);
            rl4 = 32'h7700 + 32'(w);
            #1;
            chk($sformatf("D.re.w%0d.ren", w), ren4, 1'b1);
            chk($sformatf("D.re.w%0d.dwait", w), dwait4, 4'b1101);
            chk($sformatf("D.re.w%0d.dload", w), dload4[63:32], rl4);
            if (w == 3) rd4 = '0;
        end
        @(negedge CLK); #1;
        chk("D.re.done", {ren4, dwait4}, 5'h0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
